node_detector: RTL



---
 rtl/bot_pkg.sv | 35 +++
 rtl/node_detector_if.sv | 14 +
 rtl/node_detector_pattern_debouncer.sv | 45 ++++
 rtl/node_detector.sv | 132 +++++++++++++
 4 files changed

// File: rtl/bot_pkg.sv
// Shared types for the line-following bot: LED colour codes, node detector
// state encoding and the sensor pattern that marks a node.
package bot_pkg;

  localparam int unsigned LINE_W = 3;

  // {left, centre, right} all reading black.
  localparam logic [LINE_W-1:0] LINE_ALL_BLACK = 3'b111;

  // Colour request understood by the LED driver.
  typedef enum logic [1:0] {
    GLOW_OFF   = 2'b00,
    GLOW_RED   = 2'b01,
    GLOW_BLUE  = 2'b10,
    GLOW_GREEN = 2'b11
  } glow_t;

  typedef enum logic [1:0] {
    ND_IDLE,
    ND_CONFIRM,
    ND_AT_NODE,
    ND_HOLDOFF
  } nd_state_t;

  // Step the node colour sequence RED -> BLUE -> GREEN -> RED.
  // This replaces a mod-3 divider.
  function automatic glow_t glow_rotate(input glow_t g);
    case (g)
      GLOW_RED:  return GLOW_BLUE;
      GLOW_BLUE: return GLOW_GREEN;
      default:   return GLOW_RED;
    endcase
  endfunction

endpackage

// File: rtl/node_detector_if.sv
// Node/LED bundle: the detector drives it, and the LED driver and path
// planner read it.
interface node_detector_if;
  import bot_pkg::*;

  logic       node_flag;
  logic [7:0] node;
  glow_t      glow_code;
  logic       at_node;

  modport master (output node_flag, node, glow_code, at_node);
  modport slave  (input  node_flag, node, glow_code, at_node);

endinterface

// File: rtl/node_detector_pattern_debouncer.sv
// Counts consecutive samples that match (or, with invert set, differ from)
// a pattern. stable is high in the sample that completes DEBOUNCE matches.
// The count restarts whenever arm is low or a sample breaks the run.
module pattern_debouncer
  import bot_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 1000
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic              arm,
  input  logic [LINE_W-1:0] line_sense,
  input  logic [LINE_W-1:0] pattern,
  input  logic              invert,
  output logic              stable
);

  localparam int unsigned       CNT_W = $clog2(DEBOUNCE) + 1;
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(DEBOUNCE);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;

  // Run length of qualifying samples, saturating at the limit.
  always_comb begin
    // NOTE: every signal gets a default first. No path through this block
    // leaves one unassigned, so no latch is inferred.
    hit   = (line_sense == pattern) ^ invert;
    cnt_d = '0;
    if (arm && hit) begin
      cnt_d = (cnt_q < LIMIT) ? cnt_q + CNT_W'(1) : cnt_q;
    end
  end

  assign stable = arm && hit && (cnt_q >= LIMIT - CNT_W'(1));

  // Counter register with synchronous reset.
  always_ff @(posedge clk_50M) begin
    // NOTE: non-blocking assignments, so every flop updates from values
    // taken before the edge, in any order of evaluation.
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/node_detector.sv
// Node detector. It declares a node when all three line sensors read black
// for DEBOUNCE cycles. On each node it pulses node_flag, counts the node and
// requests an LED colour for GLOW_CYCLES cycles. After the node is left, it
// ignores the line for HOLDOFF cycles.
module node_detector
  import bot_pkg::*;
#(
  parameter int unsigned DEBOUNCE    = 1000,
  parameter int unsigned HOLDOFF     = 50000,
  parameter int unsigned GLOW_CYCLES = 25_000_000
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic              enable,
  input  logic [LINE_W-1:0] line_sense,
  node_detector_if.master   nd
);

  localparam int unsigned        HOLD_W    = $clog2(HOLDOFF) + 1;
  localparam int unsigned        GLOW_W    = $clog2(GLOW_CYCLES) + 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLDOFF - 1);
  localparam logic [GLOW_W-1:0]  GLOW_LOAD = GLOW_W'(GLOW_CYCLES);

  nd_state_t         state_q, state_d;
  logic              flag_q, flag_d;
  logic [7:0]        node_q, node_d;
  glow_t             colour_q, colour_d;
  glow_t             mod3_q, mod3_d;
  logic [GLOW_W-1:0] glow_cnt_q, glow_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              confirm;

  logic entry_arm, entry_stable;
  logic exit_arm, exit_stable;

  // The entry run starts counting in IDLE. This makes the first black
  // sample count as 1.
  assign entry_arm = enable && (state_q == ND_IDLE || state_q == ND_CONFIRM);
  assign exit_arm  = enable && (state_q == ND_AT_NODE);

  pattern_debouncer #(.DEBOUNCE(DEBOUNCE)) u_entry (
    .clk_50M    (clk_50M),
    .reset      (reset),
    .arm        (entry_arm),
    .line_sense (line_sense),
    .pattern    (LINE_ALL_BLACK),
    .invert     (1'b0),
    .stable     (entry_stable)
  );

  pattern_debouncer #(.DEBOUNCE(DEBOUNCE)) u_exit (
    .clk_50M    (clk_50M),
    .reset      (reset),
    .arm        (exit_arm),
    .line_sense (line_sense),
    .pattern    (LINE_ALL_BLACK),
    .invert     (1'b1),
    .stable     (exit_stable)
  );

  // Next-state logic, holdoff count, node count and glow timer update.
  always_comb begin
    state_d    = state_q;
    flag_d     = 1'b0;
    node_d     = node_q;
    colour_d   = colour_q;
    mod3_d     = mod3_q;
    hold_d     = '0;
    confirm    = 1'b0;
    glow_cnt_d = (glow_cnt_q != '0) ? glow_cnt_q - GLOW_W'(1) : glow_cnt_q;

    if (!enable) begin
      state_d = ND_IDLE;
    end else begin
      case (state_q)
        ND_IDLE: begin
          if (entry_stable)                      confirm = 1'b1;
          else if (line_sense == LINE_ALL_BLACK) state_d = ND_CONFIRM;
        end
        ND_CONFIRM: begin
          if (entry_stable)                      confirm = 1'b1;
          else if (line_sense != LINE_ALL_BLACK) state_d = ND_IDLE;
        end
        ND_AT_NODE: begin
          if (exit_stable) state_d = ND_HOLDOFF;
        end
        ND_HOLDOFF: begin
          if (hold_q == HOLD_LAST) state_d = ND_IDLE;
          else                     hold_d  = hold_q + HOLD_W'(1);
        end
        default: state_d = ND_IDLE;
      endcase
    end

    // A confirmation restarts the glow timer, even if it is still running.
    if (confirm) begin
      state_d    = ND_AT_NODE;
      flag_d     = 1'b1;
      node_d     = node_q + 8'd1;
      colour_d   = mod3_q;
      mod3_d     = glow_rotate(mod3_q);
      glow_cnt_d = GLOW_LOAD;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state_q    <= ND_IDLE;
      flag_q     <= 1'b0;
      node_q     <= '0;
      colour_q   <= GLOW_OFF;
      mod3_q     <= GLOW_RED;
      glow_cnt_q <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      flag_q     <= flag_d;
      node_q     <= node_d;
      colour_q   <= colour_d;
      mod3_q     <= mod3_d;
      glow_cnt_q <= glow_cnt_d;
      hold_q     <= hold_d;
    end
  end

  assign nd.node_flag = flag_q;
  assign nd.node      = node_q;
  assign nd.glow_code = (glow_cnt_q != '0) ? colour_q : GLOW_OFF;
  assign nd.at_node   = (state_q == ND_AT_NODE);

endmodule
